// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath width and word type for the ALU slices
package cpu_pkg;
  localparam int DATA_W = 20;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/and_bit_slice.sv
// and_bit_slice: single-bit combinational AND cell
module and_bit_slice (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: rtl/twenty_bit_bitwise_and_core.sv
// twenty_bit_bitwise_and_core: registered bitwise AND with valid and zero flags
module twenty_bit_bitwise_and_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  input  word_t i0,
  input  word_t i1,
  output word_t s,
  output logic  out_valid,
  output logic  zero
);
  word_t and_w;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and_bit_slice u_slice (.a(i0[i]), .b(i1[i]), .y(and_w[i]));
  end
  // s and zero only load on valid cycles so idle (possibly X) operands never reach them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s         <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= and_w;
        zero <= ~|and_w;
      end
    end
  end
endmodule

// File: tb/tb_twenty_bit_bitwise_and_core.sv
// tb_twenty_bit_bitwise_and_core: scoreboard bench for the registered AND core
module tb_twenty_bit_bitwise_and_core;
  import cpu_pkg::*;
  logic  clk = 1'b0;
  logic  rst_n, in_valid, out_valid, zero;
  word_t i0, i1, s;
  logic [DATA_W:0] sb[$];
  word_t hold_s;
  logic  hold_z;
  int    n_checks = 0;
  int    n_fail = 0;
  twenty_bit_bitwise_and_core dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .i0(i0), .i1(i1),
    .s(s), .out_valid(out_valid), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // one clock of stimulus; expected result supplied by the caller
  task automatic cyc(input logic r, input logic v, input word_t a, input word_t b, input word_t exp_s);
    logic [DATA_W:0] e;
    rst_n = r; in_valid = v; i0 = a; i1 = b;
    if (r && v) sb.push_back({exp_s, exp_s == '0});
    @(posedge clk);
    #1;
    if (!r) begin
      sb.delete();
      hold_s = '0;
      hold_z = 1'b0;
    end
    check("out_valid", {31'b0, out_valid}, {31'b0, r && v});
    if (r && v) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard_empty: got none expected entry");
      end else begin
        e = sb.pop_front();
        check("s", {12'b0, s}, {12'b0, e[DATA_W:1]});
        check("zero", {31'b0, zero}, {31'b0, e[0]});
        hold_s = e[DATA_W:1];
        hold_z = e[0];
      end
    end else begin
      check(r ? "s_hold" : "s_rst", {12'b0, s}, {12'b0, hold_s});
      check(r ? "zero_hold" : "zero_rst", {31'b0, zero}, {31'b0, hold_z});
    end
  endtask
  initial begin
    word_t a, b;
    hold_s = '0; hold_z = 1'b0;
    cyc(1'b0, 1'b1, 20'hFFFFF, 20'hFFFFF, 20'h00000);
    cyc(1'b0, 1'b1, 20'hFFFFF, 20'hFFFFF, 20'h00000);
    cyc(1'b1, 1'b1, 20'h00000, 20'h00000, 20'h00000);
    cyc(1'b1, 1'b1, 20'h0005F, 20'h00000, 20'h00000);
    cyc(1'b1, 1'b1, 20'hC0003, 20'hC0003, 20'hC0003);
    cyc(1'b1, 1'b1, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);
    cyc(1'b1, 1'b1, 20'hAAAAA, 20'h55555, 20'h00000);
    cyc(1'b1, 1'b1, 20'hF0F0F, 20'hFF00F, 20'hF000F);
    cyc(1'b1, 1'b0, 20'h12345, 20'hFFFFF, 20'h00000);
    cyc(1'b1, 1'b0, 'x, 'x, 20'h00000);
    cyc(1'b1, 1'b1, 20'h80001, 20'h80000, 20'h80000);
    cyc(1'b1, 1'b1, 20'h00001, 20'h00001, 20'h00001);
    cyc(1'b0, 1'b1, 20'hFFFFF, 20'hFFFFF, 20'h00000);
    cyc(1'b1, 1'b0, 20'hFFFFF, 20'hFFFFF, 20'h00000);
    cyc(1'b1, 1'b1, 20'h3C3C3, 20'h0FF0F, 20'h0C303);
    for (int k = 0; k < 40; k++) begin
      a = word_t'($urandom);
      b = word_t'($urandom);
      if (k % 5 == 0) b = ~a;
      cyc(1'b1, ($urandom_range(0, 3) != 0), a, b, a & b);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
